// File: rtl/hpi_pkg.sv
// Shared definitions for the HPI responder: register selects, status bit
// positions, FSM state encoding and the status word builder.
package hpi_pkg;

  localparam int unsigned HPI_DW = 16;

  // Host register select values on hpi_addr
  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // Bit positions inside the STATUS word
  localparam int unsigned STAT_OUT_FULL = 0;
  localparam int unsigned STAT_IN_FULL  = 1;
  localparam int unsigned STAT_OVR      = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_DATA = 2'd1,
    S_RD_HOLD = 2'd2,
    S_WR_HOLD = 2'd3
  } hpi_state_e;

  // STATUS = {13'b0, OVR, IN_FULL, OUT_FULL}
  function automatic logic [HPI_DW-1:0] status_word(input logic ovr,
                                                    input logic in_full,
                                                    input logic out_full);
    logic [HPI_DW-1:0] w;
    w                = '0;
    w[STAT_OVR]      = ovr;
    w[STAT_IN_FULL]  = in_full;
    w[STAT_OUT_FULL] = out_full;
    return w;
  endfunction

endpackage

// File: rtl/hpi_resp_ram.sv
// Single-port synchronous RAM backing the HPI DATA register.
// Ports: clk; we/addr/wdata write port; rdata returns mem[addr] one cycle
// after addr is presented. Contents are not reset.
module hpi_resp_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem_q [DEPTH];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hpi_responder.sv
// Target-side model of the OTG host port interface. Decodes host accesses
// to DATA/MAILBOX/ADDRESS/STATUS, backs DATA with an auto-incrementing
// word RAM and provides a local-side mailbox handshake.
// Ports: clk_clk/reset_reset (async, active high); host pins hpi_addr,
// hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_in -> hpi_data_out/hpi_data_oe;
// local mailbox mbx_in_* (host->local) and mbx_out_* (local->host);
// proto_err pulses on cs with both strobes low.
module hpi_responder
  import hpi_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned RD_HOLD_MIN = 1
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [1:0]  hpi_addr,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  output logic        mbx_in_valid,
  output logic [15:0] mbx_in_data,
  input  logic        mbx_in_ack,
  input  logic        mbx_out_wr,
  input  logic [15:0] mbx_out_data,
  output logic        proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 16;

  // Registered host pins
  logic [1:0]  hpi_addr_q;
  logic        cs_n_q, r_n_q, w_n_q;
  logic [15:0] din_q;
  logic        in_vld_q;

  hpi_state_e  state_q, state_d;
  logic        prev_act_q, prev_act_d;
  logic [1:0]  rd_sel_q, rd_sel_d;
  logic [15:0] rd_val_q, rd_val_d;
  logic        rd_oob_q, rd_oob_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0] ptr_q, ptr_d;
  logic        mbx_in_valid_q, mbx_in_valid_d;
  logic [15:0] mbx_in_data_q, mbx_in_data_d;
  logic [15:0] mbx_out_q, mbx_out_d;
  logic        out_full_q, out_full_d;
  logic        ovr_q, ovr_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        proto_err_q, proto_err_d;

  logic          act, start, rd_start, wr_start, illegal, in_range;
  logic [15:0]   ptr_inc;
  logic [CW-1:0] cnt_next;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_rdata;

  hpi_resp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (din_q),
    .rdata (ram_rdata)
  );

  // Next-state, register side effects and outputs
  always_comb begin
    state_d        = state_q;
    prev_act_d     = prev_act_q;
    rd_sel_d       = rd_sel_q;
    rd_val_d       = rd_val_q;
    rd_oob_d       = rd_oob_q;
    hold_cnt_d     = hold_cnt_q;
    ptr_d          = ptr_q;
    mbx_in_valid_d = mbx_in_valid_q;
    mbx_in_data_d  = mbx_in_data_q;
    mbx_out_d      = mbx_out_q;
    out_full_d     = out_full_q;
    ovr_d          = ovr_q;
    dout_d         = dout_q;
    oe_d           = oe_q;
    proto_err_d    = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = AW'(ptr_q[15:1]);
    cnt_next       = '0;

    act      = !cs_n_q && (!r_n_q || !w_n_q);
    // First registered sample after reset holds reset values; keep the
    // "strobe active" memory until real pin samples arrive.
    start    = in_vld_q && act && !prev_act_q && (state_q == S_IDLE);
    rd_start = start && !r_n_q && w_n_q;
    wr_start = start && r_n_q && !w_n_q;
    illegal  = start && !r_n_q && !w_n_q;
    in_range = 32'(ptr_q[15:1]) < DEPTH;
    ptr_inc  = ptr_q + 16'd2;

    if (in_vld_q) begin
      prev_act_d = act;
    end

    // Local-side events; host actions below take priority where they collide
    if (mbx_out_wr) begin
      mbx_out_d = mbx_out_data;
    end
    if (mbx_in_ack) begin
      mbx_in_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (illegal) begin
          proto_err_d = 1'b1;
        end else if (wr_start) begin
          state_d = S_WR_HOLD;
          unique case (hpi_addr_q)
            HPI_DATA: begin
              ram_we = in_range;
              ptr_d  = ptr_inc;
            end
            HPI_MAILBOX: begin
              if (mbx_in_valid_q && !mbx_in_ack) begin
                ovr_d = 1'b1;
              end
              mbx_in_valid_d = 1'b1;
              mbx_in_data_d  = din_q;
            end
            HPI_ADDR: ptr_d = din_q;
            default: ;
          endcase
        end else if (rd_start) begin
          state_d  = S_RD_DATA;
          rd_sel_d = hpi_addr_q;
          rd_oob_d = !in_range;
          unique case (hpi_addr_q)
            HPI_DATA: ptr_d = ptr_inc;
            HPI_MAILBOX: begin
              rd_val_d   = mbx_out_q;
              out_full_d = 1'b0;
            end
            HPI_ADDR: rd_val_d = ptr_q;
            default: begin
              rd_val_d = status_word(ovr_q, mbx_in_valid_q, out_full_q);
              ovr_d    = 1'b0;
            end
          endcase
        end
      end
      S_RD_DATA: begin
        if (rd_sel_q == HPI_DATA) begin
          dout_d = rd_oob_q ? 16'h0000 : ram_rdata;
        end else begin
          dout_d = rd_val_q;
        end
        oe_d       = 1'b1;
        hold_cnt_d = '0;
        state_d    = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        cnt_next   = (hold_cnt_q != '1) ? hold_cnt_q + CW'(1) : hold_cnt_q;
        hold_cnt_d = cnt_next;
        if (!act && (32'(cnt_next) >= RD_HOLD_MIN)) begin
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WR_HOLD: begin
        if (!act) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A local mailbox write in the same cycle as a host read keeps OUT_FULL set
    if (mbx_out_wr) begin
      out_full_d = 1'b1;
    end
  end

  // State and pin registers
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      hpi_addr_q     <= 2'd0;
      cs_n_q         <= 1'b1;
      r_n_q          <= 1'b1;
      w_n_q          <= 1'b1;
      din_q          <= '0;
      in_vld_q       <= 1'b0;
      state_q        <= S_IDLE;
      prev_act_q     <= 1'b1;
      rd_sel_q       <= HPI_DATA;
      rd_val_q       <= '0;
      rd_oob_q       <= 1'b0;
      hold_cnt_q     <= '0;
      ptr_q          <= '0;
      mbx_in_valid_q <= 1'b0;
      mbx_in_data_q  <= '0;
      mbx_out_q      <= '0;
      out_full_q     <= 1'b0;
      ovr_q          <= 1'b0;
      dout_q         <= '0;
      oe_q           <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      hpi_addr_q     <= hpi_addr;
      cs_n_q         <= hpi_cs_n;
      r_n_q          <= hpi_r_n;
      w_n_q          <= hpi_w_n;
      din_q          <= hpi_data_in;
      in_vld_q       <= 1'b1;
      state_q        <= state_d;
      prev_act_q     <= prev_act_d;
      rd_sel_q       <= rd_sel_d;
      rd_val_q       <= rd_val_d;
      rd_oob_q       <= rd_oob_d;
      hold_cnt_q     <= hold_cnt_d;
      ptr_q          <= ptr_d;
      mbx_in_valid_q <= mbx_in_valid_d;
      mbx_in_data_q  <= mbx_in_data_d;
      mbx_out_q      <= mbx_out_d;
      out_full_q     <= out_full_d;
      ovr_q          <= ovr_d;
      dout_q         <= dout_d;
      oe_q           <= oe_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign hpi_data_out = dout_q;
  assign hpi_data_oe  = oe_q;
  assign mbx_in_valid = mbx_in_valid_q;
  assign mbx_in_data  = mbx_in_data_q;
  assign proto_err    = proto_err_q;

endmodule

// File: doc/hpi_responder.md
Name: hpi_responder

Overview:
- Target-side model of the OTG host port interface (HPI) driven by the SoC's otg_hpi_* exports.
- Decodes host accesses to the four HPI registers: DATA, MAILBOX, ADDRESS, STATUS.
- Backs DATA with a word-addressed RAM that auto-increments per access; provides a local-side mailbox handshake.
- Used as the bench/FPGA-side stand-in for the USB controller and as the responder behind the HPI I/O interface.

Parameters:
- DEPTH, 1024, RAM size in 16-bit words; power of two, at most 32768.
- RD_HOLD_MIN, 1, minimum cycles hpi_data_oe stays high after read data appears, even if the strobe drops early.

Ports:
- clk_clk  in  1  single clock.
- reset_reset  in  1  asynchronous, active-high reset.
- hpi_addr  in  2  register select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS.
- hpi_cs_n  in  1  chip select, active low.
- hpi_r_n  in  1  read strobe, active low.
- hpi_w_n  in  1  write strobe, active low.
- hpi_data_in  in  16  host write data.
- hpi_data_out  out  16  read data to host.
- hpi_data_oe  out  1  read data drive enable.
- mbx_in_valid  out  1  host-to-local mailbox holds unconsumed data.
- mbx_in_data  out  16  host-to-local mailbox value.
- mbx_in_ack  in  1  local side consumes the mailbox; clears mbx_in_valid.
- mbx_out_wr  in  1  local side writes the local-to-host mailbox.
- mbx_out_data  in  16  local-to-host mailbox value.
- proto_err  out  1  one-cycle pulse on an illegal strobe combination.

Behaviour:
- Reset (async, immediate):
  - hpi_data_out=0, hpi_data_oe=0, mbx_in_valid=0, mbx_in_data=0, proto_err=0.
  - Address register=0, both mailboxes=0, all status flags=0, FSM=IDLE.
  - RAM contents are not reset.
- Input stage: addr, cs_n, r_n, w_n and data_in are registered once.
  - The previous-strobe register resets to "active", so a strobe already held low when reset releases starts no access until it has deasserted.
- Access start: the first registered cycle with cs_n=0 and exactly one of r_n/w_n=0.
  - cs_n=0 with both r_n and w_n low pulses proto_err, performs no action, and the FSM stays in IDLE.
- FSM states: IDLE, RD_DATA, RD_HOLD, WR_HOLD.
  - IDLE -> WR_HOLD on write start. The write commits on the start cycle.
  - IDLE -> RD_DATA on read start. Next cycle, hpi_data_out loads the selected value, hpi_data_oe=1, and the FSM moves to RD_HOLD.
  - RD_HOLD: hold hpi_data_out/oe until the registered strobe deasserts and at least RD_HOLD_MIN cycles have elapsed, then oe=0 and return to IDLE.
  - WR_HOLD: return to IDLE when the registered strobe deasserts.
  - Read latency: data valid 2 cycles after the registered start (3 after the raw pin edge).
- Register semantics:
  - ADDRESS write: load the byte address. ADDRESS read returns it.
  - DATA access: word index = addr[15:1]. Write stores the word; read returns the word. Either way the address then increments by 2, wrapping 16'hFFFE -> 16'h0000.
  - Indices >= DEPTH: writes are dropped and reads return 16'h0000; the address still increments.
  - MAILBOX write: mbx_in_data <= data, mbx_in_valid=1. If already valid, also set sticky OVR.
  - MAILBOX read: returns the local-to-host mailbox value and clears OUT_FULL.
  - STATUS read: {13'b0, OVR, IN_FULL=mbx_in_valid, OUT_FULL}. The read clears OVR.
  - STATUS write: ignored.
- Local side:
  - mbx_out_wr stores mbx_out_data and sets OUT_FULL.
  - mbx_in_ack clears mbx_in_valid.
- Simultaneous events:
  - mbx_out_wr in the same cycle as a host MAILBOX read: the set wins, OUT_FULL stays 1, the new value is stored, and the host receives the old value.
  - mbx_in_ack in the same cycle as a host MAILBOX write: the write wins, valid stays 1, and OVR is not set.
  - An OVR set in the same cycle as a STATUS read: OVR stays set.
- Reset mid-access: oe drops immediately; the partial access has no further effect.

Decomposition:
- Shared package hpi_pkg:
  - register select constants HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDR=2'd2, HPI_STATUS=2'd3;
  - status bit positions;
  - FSM state enum.
- One sub-module: hpi_resp_ram, a single-port synchronous RAM of DEPTH x 16 with 1-cycle read.

Test Plan:
- Write ADDRESS=16'h0010, then DATA writes 16'hAAAA and 16'h5555; write ADDRESS=16'h0010 and read DATA twice -> 16'hAAAA then 16'h5555, each with oe high 2 cycles after the registered start; ADDRESS reads back 16'h0014.
- ADDRESS=16'hFFFE, DATA write 16'h1234 -> index beyond DEPTH is dropped; ADDRESS reads back 16'h0000; a DATA read at 0 returns the prior contents.
- Host MAILBOX write 16'h00C3 -> mbx_in_valid=1, mbx_in_data=16'h00C3, STATUS=16'h0002. A second write without ack -> STATUS=16'h0006, then the next STATUS read returns 16'h0002.
- mbx_out_wr 16'hBEEF -> STATUS bit0=1. Host MAILBOX read -> 16'hBEEF, bit0 clears. Repeat with mbx_out_wr in the same cycle as the read -> bit0 stays 1.
- cs_n=0 with r_n=0 and w_n=0 -> one proto_err pulse, no RAM/address change, oe stays 0.
- Assert reset during RD_HOLD with the strobe held low -> oe=0 asynchronously; after release, no read occurs until the strobe toggles high then low.
